// File: rtl/lfsr_seq_gen_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the LFSR sequence generator:
//   - state_e      : generator FSM states (IDLE, RUN, DONE)
//   - DEF_TAPS     : default Fibonacci feedback mask (taps 31, 29, 25, 2)
//   - DEF_SEED     : default reset seed, also substituted for a zero seed
//   - ZERO_SEED    : the lock-up state the LFSR must never hold
// No ports (package).
// -----------------------------------------------------------------------------
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] DEF_TAPS  = 32'hA200_0004;
  localparam logic [31:0] DEF_SEED  = 32'h60BC_D9BE;
  // An all-zero XOR LFSR never leaves zero, so a zero seed is replaced.
  localparam logic [31:0] ZERO_SEED = 32'h0000_0000;

endpackage

// File: rtl/lfsr_seq_gen_if.sv
// -----------------------------------------------------------------------------
// lfsr_seq_gen_if
// Control/data bundle between a host (master) and the generator (slave).
//   start     host->gen  begin or restart generation (pulse)
//   enable    host->gen  step permission while running; 0 = hold
//   seed_load host->gen  load seed_in into the LFSR (IDLE/DONE only)
//   seed_in   host->gen  LFSR_W-bit seed value
//   busy      gen->host  high while generating
//   done      gen->host  high when the sequence is complete
//   seq_out   gen->host  {sequence, PAD_W zeros} while done, else zero
// -----------------------------------------------------------------------------
interface lfsr_seq_gen_if #(
  parameter int LFSR_W = 32,
  parameter int SEQ_W  = 256,
  parameter int PAD_W  = 32
);

  logic                     start;
  logic                     enable;
  logic                     seed_load;
  logic [LFSR_W-1:0]        seed_in;
  logic                     busy;
  logic                     done;
  logic [SEQ_W+PAD_W-1:0]   seq_out;

  modport master (
    output start, enable, seed_load, seed_in,
    input  busy, done, seq_out
  );

  modport slave (
    input  start, enable, seed_load, seed_in,
    output busy, done, seq_out
  );

endinterface

// File: rtl/lfsr_seq_gen_core.sv
// -----------------------------------------------------------------------------
// lfsr_core
// Fibonacci LFSR register with a BITS_PER_CYC-step unrolled advance.
//   i_clk        clock, posedge
//   i_reset      synchronous active-high reset (state <- SEED_DEFAULT)
//   i_load       load i_load_val (zero is replaced by SEED_DEFAULT)
//   i_load_val   seed value
//   i_advance    perform BITS_PER_CYC chained steps this cycle
//   o_state      current LFSR state
//   o_step_bits  feedback bits of this cycle's steps, earliest step in MSB
// -----------------------------------------------------------------------------
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int                LFSR_W       = 32,
  parameter logic [LFSR_W-1:0] TAPS         = LFSR_W'(DEF_TAPS),
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = LFSR_W'(DEF_SEED),
  parameter int                BITS_PER_CYC = 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_load,
  input  logic [LFSR_W-1:0]       i_load_val,
  input  logic                    i_advance,
  output logic [LFSR_W-1:0]       o_state,
  output logic [BITS_PER_CYC-1:0] o_step_bits
);

  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_next;
  logic [LFSR_W-1:0] w_seed;

  // Chain BITS_PER_CYC single steps; step k's bit lands at MSB-k.
  always_comb begin : adv
    logic fb;
    fb          = 1'b0;
    w_next      = r_lfsr;
    o_step_bits = '0;
    for (int k = 0; k < BITS_PER_CYC; k++) begin
      fb                            = ^(w_next & TAPS);
      o_step_bits[BITS_PER_CYC-1-k] = fb;
      w_next                        = {w_next[LFSR_W-2:0], fb};
    end
  end

  // Zero-seed guard.
  always_comb begin
    if (i_load_val == LFSR_W'(ZERO_SEED)) begin
      w_seed = SEED_DEFAULT;
    end else begin
      w_seed = i_load_val;
    end
  end

  // LFSR state register: reset, load, advance or hold.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lfsr <= SEED_DEFAULT;
    end else if (i_load) begin
      r_lfsr <= w_seed;
    end else if (i_advance) begin
      r_lfsr <= w_next;
    end else begin
      r_lfsr <= r_lfsr;
    end
  end

  assign o_state = r_lfsr;

endmodule

// File: rtl/lfsr_seq_gen.sv
// -----------------------------------------------------------------------------
// lfsr_seq_gen
// Pseudo-random sequence generator: collects SEQ_W LFSR output bits,
// BITS_PER_CYC per enabled cycle, and presents {gen, PAD_W zeros} when done.
//   i_clk    clock, posedge
//   i_reset  synchronous active-high reset
//   io_bus   lfsr_seq_gen_if.slave (start/enable/seed_load/seed_in in,
//            busy/done/seq_out out)
// -----------------------------------------------------------------------------
module lfsr_seq_gen
  import lfsr_pkg::*;
#(
  parameter int                LFSR_W       = 32,
  parameter logic [LFSR_W-1:0] TAPS         = LFSR_W'(DEF_TAPS),
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = LFSR_W'(DEF_SEED),
  parameter int                SEQ_W        = 256,
  parameter int                BITS_PER_CYC = 1,
  parameter int                PAD_W        = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  lfsr_seq_gen_if.slave io_bus
);

  localparam int N_STEPS = SEQ_W / BITS_PER_CYC;
  localparam int CNT_W   = $clog2(N_STEPS + 1);

  state_e                   r_state;
  logic [CNT_W-1:0]         r_count;
  logic [SEQ_W-1:0]         r_gen;
  logic                     r_busy;
  logic                     r_done;
  logic [SEQ_W+PAD_W-1:0]   r_seq_out;

  logic                          w_load;
  logic                          w_advance;
  logic [BITS_PER_CYC-1:0]       w_step_bits;
  logic [LFSR_W-1:0]             w_lfsr_state;
  logic [SEQ_W+BITS_PER_CYC-1:0] w_gen_wide;
  logic [SEQ_W-1:0]              w_gen_next;

  // Seeds are only accepted outside RUN; the LFSR moves only on enabled RUN cycles.
  always_comb begin
    w_load     = io_bus.seed_load & (r_state != ST_RUN);
    w_advance  = io_bus.enable & (r_state == ST_RUN);
    w_gen_wide = {r_gen, w_step_bits};
    w_gen_next = w_gen_wide[SEQ_W-1:0];
  end

  lfsr_core #(
    .LFSR_W       (LFSR_W),
    .TAPS         (TAPS),
    .SEED_DEFAULT (SEED_DEFAULT),
    .BITS_PER_CYC (BITS_PER_CYC)
  ) u_core (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_load),
    .i_load_val  (io_bus.seed_in),
    .i_advance   (w_advance),
    .o_state     (w_lfsr_state),
    .o_step_bits (w_step_bits)
  );

  // Generator FSM with count, gen shift register and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_gen     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_seq_out <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (io_bus.start) begin
            r_state   <= ST_RUN;
            r_gen     <= '0;
            r_count   <= CNT_W'(N_STEPS);
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_seq_out <= '0;
          end
        end
        ST_RUN: begin
          if (io_bus.enable) begin
            r_gen   <= w_gen_next;
            r_count <= r_count - CNT_W'(1);
            // Last group: publish the sequence together with done.
            if (r_count == CNT_W'(1)) begin
              r_state   <= ST_DONE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_seq_out <= {w_gen_next, {PAD_W{1'b0}}};
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_seq_out <= '0;
        end
      endcase
    end
  end

  assign io_bus.busy    = r_busy;
  assign io_bus.done    = r_done;
  assign io_bus.seq_out = r_seq_out;

endmodule

// File: tb/tb_lfsr_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_lfsr_seq_gen
// Self-checking bench: a BITS_PER_CYC=1 and a BITS_PER_CYC=8 generator are
// compared against a bit-serial reference LFSR kept in the bench.
// -----------------------------------------------------------------------------
module tb_lfsr_seq_gen;

  localparam logic [31:0] TAPS = 32'hA200_0004;
  localparam logic [31:0] SEED = 32'h60BC_D9BE;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  lfsr_seq_gen_if #(.LFSR_W(32), .SEQ_W(256), .PAD_W(32)) bus1 ();
  lfsr_seq_gen_if #(.LFSR_W(32), .SEQ_W(256), .PAD_W(32)) bus8 ();

  lfsr_seq_gen #(
    .LFSR_W(32), .TAPS(TAPS), .SEED_DEFAULT(SEED),
    .SEQ_W(256), .BITS_PER_CYC(1), .PAD_W(32)
  ) dut1 (.i_clk(clk), .i_reset(rst), .io_bus(bus1));

  lfsr_seq_gen #(
    .LFSR_W(32), .TAPS(TAPS), .SEED_DEFAULT(SEED),
    .SEQ_W(256), .BITS_PER_CYC(8), .PAD_W(32)
  ) dut8 (.i_clk(clk), .i_reset(rst), .io_bus(bus8));

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] m_lfsr;

  task automatic chk_val(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: one Fibonacci step, feedback is the parity of the tapped bits.
  function automatic logic model_step();
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < 32; i++) if (TAPS[i]) fb = fb ^ m_lfsr[i];
    m_lfsr = (m_lfsr << 1) | {31'd0, fb};
    return fb;
  endfunction

  // Reference: next 256 emitted bits, first emitted bit in the MSB.
  function automatic logic [255:0] model_gen();
    logic [255:0] g;
    g = '0;
    for (int i = 0; i < 256; i++) g = (g << 1) | {255'd0, model_step()};
    return g;
  endfunction

  function automatic logic [31:0] subst(input logic [31:0] s);
    return (s == 32'd0) ? SEED : s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus1.start = 1'b0; bus1.enable = 1'b0; bus1.seed_load = 1'b0; bus1.seed_in = 32'd0;
    bus8.start = 1'b0; bus8.enable = 1'b0; bus8.seed_load = 1'b0; bus8.seed_in = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    m_lfsr = SEED;
  endtask

  task automatic load_seed(input logic [31:0] s);
    bus1.seed_in   = s;
    bus1.seed_load = 1'b1;
    @(negedge clk);
    bus1.seed_load = 1'b0;
    m_lfsr = subst(s);
  endtask

  // mode 0: enable high, 1: toggle starting at 0, 2: random enable.
  task automatic run_gen(input string tag, input int mode, input bit with_load,
                         input logic [31:0] seed, input bit chk_first,
                         output logic [255:0] got);
    logic [255:0] exp;
    int cyc;
    int steps;
    logic en;
    cyc = 0;
    steps = 0;
    if (with_load) begin
      bus1.seed_in   = seed;
      bus1.seed_load = 1'b1;
      m_lfsr = subst(seed);
    end
    exp = model_gen();
    bus1.start  = 1'b1;
    bus1.enable = 1'b0;
    @(negedge clk);
    bus1.start     = 1'b0;
    bus1.seed_load = 1'b0;
    chk_val({tag, "_busy_at_start"}, bus1.busy, 288'd1);
    chk_val({tag, "_done_at_start"}, bus1.done, 288'd0);
    chk_val({tag, "_seq_at_start"}, bus1.seq_out, 288'd0);
    while (!bus1.done && cyc < 3000) begin
      case (mode)
        0:       en = 1'b1;
        1:       en = cyc[0];
        default: en = 1'($urandom_range(0, 1));
      endcase
      bus1.enable = en;
      @(negedge clk);
      cyc++;
      if (en) steps++;
      if (chk_first && cyc == 1) begin
        chk_val({tag, "_first_lfsr"}, dut1.w_lfsr_state, 288'hC179_B37C);
        chk_val({tag, "_first_bit"}, dut1.r_gen[0], 288'd0);
      end
      if (cyc == 100) chk_val({tag, "_seq_mid_run"}, bus1.seq_out, 288'd0);
    end
    bus1.enable = 1'b0;
    chk_val({tag, "_steps"}, steps, 288'd256);
    if (mode == 0) chk_val({tag, "_cycles"}, cyc, 288'd256);
    if (mode == 1) chk_val({tag, "_cycles"}, cyc, 288'd512);
    chk_val({tag, "_busy_end"}, bus1.busy, 288'd0);
    chk_val({tag, "_done_end"}, bus1.done, 288'd1);
    chk_val({tag, "_seq"}, bus1.seq_out, {exp, 32'd0});
    chk_val({tag, "_lfsr_end"}, dut1.w_lfsr_state, m_lfsr);
    got = bus1.seq_out[287:32];
  endtask

  initial begin
    logic [255:0] g_a, g_b, g_c, g_d, exp8;
    logic [99:0]  part;
    logic [31:0]  s;
    int cyc;

    rst = 1'b1;
    bus1.start = 1'b0; bus1.enable = 1'b0; bus1.seed_load = 1'b0; bus1.seed_in = 32'd0;
    bus8.start = 1'b0; bus8.enable = 1'b0; bus8.seed_load = 1'b0; bus8.seed_in = 32'd0;
    m_lfsr = SEED;

    // Reset state.
    do_reset();
    chk_val("rst_busy", bus1.busy, 288'd0);
    chk_val("rst_done", bus1.done, 288'd0);
    chk_val("rst_seq", bus1.seq_out, 288'd0);
    chk_val("rst_lfsr", dut1.w_lfsr_state, SEED);

    // Default run, then a back-to-back restart continuing the stream.
    run_gen("dflt", 0, 1'b0, 32'd0, 1'b1, g_a);
    run_gen("b2b", 0, 1'b0, 32'd0, 1'b0, g_b);
    chk_val("b2b_differs", (g_b != g_a), 288'd1);

    // Toggled enable from the same seed gives the same sequence.
    do_reset();
    run_gen("tgl", 1, 1'b0, 32'd0, 1'b0, g_c);
    chk_val("tgl_same_as_dflt", g_c, g_a);

    // Seed loads in IDLE, including the zero-seed substitution.
    do_reset();
    s = $urandom | 32'd1;
    load_seed(s);
    chk_val("seed_rand_lfsr", dut1.w_lfsr_state, s);
    load_seed(32'd0);
    chk_val("seed_zero_lfsr", dut1.w_lfsr_state, SEED);
    run_gen("seed1", 2, 1'b1, 32'h0000_0001, 1'b0, g_d);

    // Random seeds loaded together with start from DONE, random enable.
    for (int i = 0; i < 3; i++) run_gen("rnd", 2, 1'b1, $urandom, 1'b0, g_d);

    // start/seed_load inside RUN are ignored; reset mid-RUN discards everything.
    do_reset();
    part = '0;
    bus1.start  = 1'b1;
    bus1.enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      bus1.start     = (i == 50);
      bus1.seed_load = (i == 50);
      bus1.seed_in   = $urandom;
      @(negedge clk);
      part = {part[98:0], model_step()};
    end
    bus1.start = 1'b0;
    bus1.seed_load = 1'b0;
    chk_val("run_ign_lfsr", dut1.w_lfsr_state, m_lfsr);
    chk_val("run_ign_gen", dut1.r_gen[99:0], part);
    chk_val("run_ign_busy", bus1.busy, 288'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus1.enable = 1'b0;
    chk_val("midrst_busy", bus1.busy, 288'd0);
    chk_val("midrst_done", bus1.done, 288'd0);
    chk_val("midrst_seq", bus1.seq_out, 288'd0);
    chk_val("midrst_lfsr", dut1.w_lfsr_state, SEED);

    // BITS_PER_CYC=8: seed_load and start together, 32 enabled cycles.
    s = $urandom;
    m_lfsr = subst(s);
    exp8 = model_gen();
    bus8.seed_in   = s;
    bus8.seed_load = 1'b1;
    bus8.start     = 1'b1;
    bus8.enable    = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.seed_load = 1'b0;
    cyc = 0;
    while (!bus8.done && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    bus8.enable = 1'b0;
    chk_val("bpc8_cycles", cyc, 288'd32);
    chk_val("bpc8_busy", bus8.busy, 288'd0);
    chk_val("bpc8_seq", bus8.seq_out, {exp8, 32'd0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
